main_mem_responder: RTL and testbench

Synthesizable main-memory responder: the memory-side end of the cached CPU's line-granular main-memory interface (`mem_req_*` / `mem_resp_*`). It accepts one 256-bit line read or write at a time and returns `mem_resp_valid` exactly `LATENCY` cycles later. It stands in for DRAM/AXI in synthesis-level and FPGA bring-up builds. A backdoor init port preloads program images.

---
 rtl/shoumei_mem_pkg.sv | 23 ++
 rtl/main_mem_line_array.sv | 40 ++++
 rtl/main_mem_responder.sv | 137 +++++++++++++
 tb/tb_main_mem_responder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shoumei_mem_pkg.sv
// Shared definitions for the line-granular main-memory interface.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shoumei_mem_pkg;

    localparam int LINE_W     = 256;
    localparam int LINE_BYTES = 32;
    localparam int LINE_OFF_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_resp_state_e;

    // One line request as presented by the initiator
    typedef struct packed {
        logic [31:0]       addr;
        logic              we;
        logic [LINE_W-1:0] data;
    } mem_req_t;

endpackage

// File: rtl/main_mem_line_array.sv
// Line storage: port A synchronous read/write (write-first), port B write-only.
// Latency: port A read data valid the cycle after the enabled edge; held until the next enable.
// Backpressure: none; both ports accept every cycle, port A wins a same-index collision.
module main_mem_line_array
    import shoumei_mem_pkg::*;
#(
    parameter  int DEPTH_LINES = 1024,
    localparam int IDX_W       = $clog2(DEPTH_LINES)
) (
    input  logic              clock,
    input  logic              a_en,
    input  logic              a_we,
    input  logic [IDX_W-1:0]  a_index,
    input  logic [LINE_W-1:0] a_wdata,
    output logic [LINE_W-1:0] a_rdata,
    input  logic              b_we,
    input  logic [IDX_W-1:0]  b_index,
    input  logic [LINE_W-1:0] b_wdata
);

    logic [LINE_W-1:0] mem [DEPTH_LINES];

    // Array writes; port A is written last so it overrides port B on the same index
    always_ff @(posedge clock) begin
        if (b_we) begin
            mem[b_index] <= b_wdata;
        end
        if (a_en && a_we) begin
            mem[a_index] <= a_wdata;
        end
    end

    // Port A output register; only loads when enabled so a pending line is never disturbed
    always_ff @(posedge clock) begin
        if (a_en) begin
            a_rdata <= a_we ? a_wdata : mem[a_index];
        end
    end

endmodule

// File: rtl/main_mem_responder.sv
// Memory-side responder: one 256-bit line read/write at a time, backdoor init port.
// Latency: mem_resp_valid exactly LATENCY cycles after acceptance, one-cycle pulse.
// Backpressure: accepts only in IDLE; initiator holds its request until it sees the response.
module main_mem_responder
    import shoumei_mem_pkg::*;
#(
    parameter  int LATENCY     = 4,
    parameter  int DEPTH_LINES = 1024,
    localparam int IDX_W       = $clog2(DEPTH_LINES)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_req_valid,
    input  logic [31:0]       mem_req_addr,
    input  logic              mem_req_we,
    input  logic [LINE_W-1:0] mem_req_data,
    output logic              mem_resp_valid,
    output logic [LINE_W-1:0] mem_resp_data,
    input  logic              init_valid,
    input  logic [IDX_W-1:0]  init_index,
    input  logic [LINE_W-1:0] init_data,
    output logic              busy,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count,
    output logic              proto_err
);

    localparam logic [7:0] CNT_LAST = 8'(LATENCY - 1);

    mem_resp_state_e   state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              accept;
    logic              violation;
    mem_req_t          req_in, req_q;
    logic              resp_q;
    logic              busy_q;
    logic [31:0]       rd_count_q, wr_count_q;
    logic              proto_q;
    logic [LINE_W-1:0] line_q;

    assign req_in = '{addr: mem_req_addr, we: mem_req_we, data: mem_req_data};

    // Next-state, wait counter and acceptance strobe
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        violation = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 8'd1;
                    end
                end
            end
            WAIT: begin
                violation = !mem_req_valid || (req_in != req_q);
                if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and wait counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request latch, registered status outputs, counters and sticky error flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_q      <= '0;
            resp_q     <= 1'b0;
            busy_q     <= 1'b0;
            rd_count_q <= 32'd0;
            wr_count_q <= 32'd0;
            proto_q    <= 1'b0;
        end else begin
            resp_q <= (state_d == RESP);
            busy_q <= (state_d != IDLE);
            if (accept) begin
                req_q <= req_in;
                if (mem_req_we) begin
                    wr_count_q <= wr_count_q + 32'd1;
                end else begin
                    rd_count_q <= rd_count_q + 32'd1;
                end
            end
            if (violation) begin
                proto_q <= 1'b1;
            end
        end
    end

    main_mem_line_array #(
        .DEPTH_LINES (DEPTH_LINES)
    ) u_array (
        .clock   (clock),
        .a_en    (accept),
        .a_we    (mem_req_we),
        .a_index (mem_req_addr[LINE_OFF_W +: IDX_W]),
        .a_wdata (mem_req_data),
        .a_rdata (line_q),
        .b_we    (init_valid),
        .b_index (init_index),
        .b_wdata (init_data)
    );

    // The array register holds the read line or the echoed write data; gate it outside the pulse
    assign mem_resp_valid = resp_q;
    assign mem_resp_data  = resp_q ? line_q : '0;
    assign busy           = busy_q;
    assign rd_count       = rd_count_q;
    assign wr_count       = wr_count_q;
    assign proto_err      = proto_q;

endmodule

// File: tb/tb_main_mem_responder.sv
module tb_main_mem_responder;

    localparam int LAT = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         mem_req_valid = 1'b0;
    logic [31:0]  mem_req_addr = '0;
    logic         mem_req_we = 1'b0;
    logic [255:0] mem_req_data = '0;
    logic         mem_resp_valid;
    logic [255:0] mem_resp_data;
    logic         init_valid = 1'b0;
    logic [9:0]   init_index = '0;
    logic [255:0] init_data = '0;
    logic         busy;
    logic [31:0]  rd_count;
    logic [31:0]  wr_count;
    logic         proto_err;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [255:0] P = {8{32'hA5A5_0003}};
    localparam logic [255:0] D = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] E = {8{32'h0BAD_F00D}};
    localparam logic [255:0] W = {8{32'h1111_2222}};
    localparam logic [255:0] V = {8{32'h3333_4444}};
    localparam logic [255:0] Q = {8{32'h5555_6666}};

    main_mem_responder #(
        .LATENCY     (LAT),
        .DEPTH_LINES (1024)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_we     (mem_req_we),
        .mem_req_data   (mem_req_data),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .init_valid     (init_valid),
        .init_index     (init_index),
        .init_data      (init_data),
        .busy           (busy),
        .rd_count       (rd_count),
        .wr_count       (wr_count),
        .proto_err      (proto_err)
    );

    always #5 clock = ~clock;

    // Drives one request starting in the current cycle (cycle 0, called at a negedge),
    // records the first response cycle, its data and the pulse count over 10 cycles.
    task automatic run_req(input logic [31:0] a, input logic w, input logic [255:0] d,
                           output int first, output int pulses, output logic [255:0] dat);
        first = -1;
        pulses = 0;
        dat = '0;
        mem_req_valid = 1'b1;
        mem_req_addr = a;
        mem_req_we = w;
        mem_req_data = d;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (mem_resp_valid === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first = c;
                    dat = mem_resp_data;
                end
                mem_req_valid = 1'b0;
            end
        end
        mem_req_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        vectors++; if (mem_resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid got %b want 0", mem_resp_valid); end
        vectors++; if (mem_resp_data !== 256'd0) begin miscompares++; $display("FAIL reset_resp_data got %h want 0", mem_resp_data); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (rd_count !== 32'd0) begin miscompares++; $display("FAIL reset_rd_count got %0d want 0", rd_count); end
        vectors++; if (wr_count !== 32'd0) begin miscompares++; $display("FAIL reset_wr_count got %0d want 0", wr_count); end
        vectors++; if (proto_err !== 1'b0) begin miscompares++; $display("FAIL reset_proto_err got %b want 0", proto_err); end
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            vectors++; if (mem_resp_valid !== 1'b0) begin miscompares++; $display("FAIL idle_resp_valid cycle %0d got %b want 0", c, mem_resp_valid); end
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy cycle %0d got %b want 0", c, busy); end
        end
    endtask

    task automatic test_preload_read();
        logic         exp_v;
        logic         exp_b;
        logic [255:0] exp_d;
        init_valid = 1'b1;
        init_index = 10'd3;
        init_data = P;
        @(negedge clock);
        init_valid = 1'b0;
        mem_req_valid = 1'b1;
        mem_req_addr = 32'h0000_0060;
        mem_req_we = 1'b0;
        mem_req_data = '0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            exp_v = (c == LAT);
            exp_b = (c >= 1 && c <= LAT);
            exp_d = (c == LAT) ? P : 256'd0;
            vectors++; if (mem_resp_valid !== exp_v) begin miscompares++; $display("FAIL preload_resp_valid cycle %0d got %b want %b", c, mem_resp_valid, exp_v); end
            vectors++; if (mem_resp_data !== exp_d) begin miscompares++; $display("FAIL preload_resp_data cycle %0d got %h want %h", c, mem_resp_data, exp_d); end
            vectors++; if (busy !== exp_b) begin miscompares++; $display("FAIL preload_busy cycle %0d got %b want %b", c, busy, exp_b); end
            if (c == 1) begin
                vectors++; if (rd_count !== 32'd1) begin miscompares++; $display("FAIL preload_rd_count got %0d want 1", rd_count); end
            end
            if (c == LAT) mem_req_valid = 1'b0;
        end
    endtask

    task automatic test_write_read();
        int           first;
        int           pulses;
        logic [255:0] dat;
        pulse_reset();
        run_req(32'h0000_0080, 1'b1, D, first, pulses, dat);
        vectors++; if (first !== LAT) begin miscompares++; $display("FAIL wr_resp_cycle got %0d want %0d", first, LAT); end
        vectors++; if (dat !== D) begin miscompares++; $display("FAIL wr_echo got %h want %h", dat, D); end
        vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL wr_pulses got %0d want 1", pulses); end
        run_req(32'h0000_009F, 1'b0, '0, first, pulses, dat);
        vectors++; if (dat !== D) begin miscompares++; $display("FAIL raw_data got %h want %h", dat, D); end
        vectors++; if (first !== LAT) begin miscompares++; $display("FAIL raw_resp_cycle got %0d want %0d", first, LAT); end
        run_req(32'h0000_8080, 1'b0, '0, first, pulses, dat);
        vectors++; if (dat !== D) begin miscompares++; $display("FAIL alias_data got %h want %h", dat, D); end
        vectors++; if (wr_count !== 32'd1) begin miscompares++; $display("FAIL wr_count got %0d want 1", wr_count); end
        vectors++; if (rd_count !== 32'd2) begin miscompares++; $display("FAIL rd_count got %0d want 2", rd_count); end
    endtask

    task automatic test_back_to_back();
        logic         exp_v;
        logic         prev;
        int           doubles;
        logic [255:0] d_first;
        logic [255:0] d_second;
        prev = 1'b0;
        doubles = 0;
        d_first = '0;
        d_second = '0;
        mem_req_valid = 1'b1;
        mem_req_addr = 32'h0000_0060;
        mem_req_we = 1'b0;
        mem_req_data = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            exp_v = (c == LAT) || (c == 2 * LAT + 1);
            vectors++; if (mem_resp_valid !== exp_v) begin miscompares++; $display("FAIL b2b_resp_valid cycle %0d got %b want %b", c, mem_resp_valid, exp_v); end
            if (prev && mem_resp_valid) doubles++;
            prev = mem_resp_valid;
            if (c == LAT) d_first = mem_resp_data;
            if (c == 2 * LAT + 1) begin
                d_second = mem_resp_data;
                mem_req_valid = 1'b0;
            end
            if (c == LAT + 1) begin
                mem_req_addr = 32'h0000_00A0;
                mem_req_we = 1'b1;
                mem_req_data = E;
            end
        end
        vectors++; if (doubles !== 0) begin miscompares++; $display("FAIL b2b_double_pulse got %0d want 0", doubles); end
        vectors++; if (d_first !== P) begin miscompares++; $display("FAIL b2b_first_data got %h want %h", d_first, P); end
        vectors++; if (d_second !== E) begin miscompares++; $display("FAIL b2b_second_data got %h want %h", d_second, E); end
        vectors++; if (proto_err !== 1'b0) begin miscompares++; $display("FAIL b2b_proto_err got %b want 0", proto_err); end
    endtask

    task automatic test_proto_err();
        logic exp_p;
        logic exp_v;
        mem_req_valid = 1'b1;
        mem_req_addr = 32'h0000_0060;
        mem_req_we = 1'b0;
        mem_req_data = '0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            exp_p = (c >= 3);
            exp_v = (c == LAT);
            vectors++; if (proto_err !== exp_p) begin miscompares++; $display("FAIL proto_err cycle %0d got %b want %b", c, proto_err, exp_p); end
            vectors++; if (mem_resp_valid !== exp_v) begin miscompares++; $display("FAIL proto_resp_valid cycle %0d got %b want %b", c, mem_resp_valid, exp_v); end
            if (c == LAT) begin
                vectors++; if (mem_resp_data !== P) begin miscompares++; $display("FAIL proto_resp_data got %h want %h", mem_resp_data, P); end
            end
            if (c == 2) mem_req_valid = 1'b0;
        end
    endtask

    task automatic test_reset_mid_op();
        int           first;
        int           pulses;
        logic [255:0] dat;
        pulses = 0;
        mem_req_valid = 1'b1;
        mem_req_addr = 32'h0000_0060;
        mem_req_we = 1'b0;
        mem_req_data = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        mem_req_valid = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b want 0", busy); end
        vectors++; if (rd_count !== 32'd0) begin miscompares++; $display("FAIL midrst_rd_count got %0d want 0", rd_count); end
        vectors++; if (wr_count !== 32'd0) begin miscompares++; $display("FAIL midrst_wr_count got %0d want 0", wr_count); end
        vectors++; if (proto_err !== 1'b0) begin miscompares++; $display("FAIL midrst_proto_err got %b want 0", proto_err); end
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (mem_resp_valid !== 1'b0) pulses++;
        end
        vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL midrst_dropped_resp got %0d pulses want 0", pulses); end
        run_req(32'h0000_0060, 1'b0, '0, first, pulses, dat);
        vectors++; if (dat !== P) begin miscompares++; $display("FAIL midrst_retained got %h want %h", dat, P); end
        vectors++; if (first !== LAT) begin miscompares++; $display("FAIL midrst_resp_cycle got %0d want %0d", first, LAT); end
    endtask

    task automatic test_init_collision();
        int           first;
        int           pulses;
        logic [255:0] dat;
        init_valid = 1'b1;
        init_index = 10'd6;
        init_data = V;
        fork
            run_req(32'h0000_00C0, 1'b1, W, first, pulses, dat);
            begin
                @(negedge clock);
                init_valid = 1'b0;
            end
        join
        run_req(32'h0000_00C0, 1'b0, '0, first, pulses, dat);
        vectors++; if (dat !== W) begin miscompares++; $display("FAIL collision_winner got %h want %h", dat, W); end
    endtask

    task automatic test_init_pending();
        int           first;
        int           pulses;
        logic [255:0] dat;
        fork
            run_req(32'h0000_0060, 1'b0, '0, first, pulses, dat);
            begin
                @(negedge clock);
                @(negedge clock);
                init_valid = 1'b1;
                init_index = 10'd3;
                init_data = Q;
                @(negedge clock);
                init_valid = 1'b0;
            end
        join
        vectors++; if (dat !== P) begin miscompares++; $display("FAIL pending_unaltered got %h want %h", dat, P); end
        run_req(32'h0000_0060, 1'b0, '0, first, pulses, dat);
        vectors++; if (dat !== Q) begin miscompares++; $display("FAIL init_applied got %h want %h", dat, Q); end
    endtask

    initial begin
        test_reset();
        test_preload_read();
        test_write_read();
        test_back_to_back();
        test_proto_err();
        test_reset_mid_op();
        test_init_collision();
        test_init_pending();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
